tree_node_loader: RTL and testbench

Configuration-side writer for the packet-classification tree. Accepts a byte-serial load stream over a valid/ready handshake, assembles NODE_WIDTH-bit node words, and writes them into either the root-node register or the level-2 node table through the table's write port. It is the write-side counterpart of the root lookup stage, which only reads these locations. It sits between the host configuration interface and the root stage's node storage.

---
 rtl/tree_pkg.sv | 33 +++
 rtl/tree_node_loader_if.sv | 18 +
 rtl/node_assembler.sv | 37 +++
 rtl/tree_node_loader.sv | 154 +++++++++++++++
 tb/tb_tree_node_loader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tree_pkg.sv
// Shared types and defaults for the classification-tree loader.
// LOADER_CHECKSUM_EN adds the trailing checksum byte and its CSUM state.
package tree_pkg;

    localparam int NODE_WIDTH_DEF = 40;
    localparam int NODE_ADDR_DEF  = 9;

    localparam logic [39:0] ROOT_INIT_DEF =
        40'b000000000_00011111_00001101_00000010_111_000_0;

    localparam logic [7:0] TGT_ROOT = 8'd0;
    localparam logic [7:0] TGT_L2   = 8'd1;

`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DRAIN,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/tree_node_loader_if.sv
// Load-stream handshake plus table write port of the tree node loader.
// Same signals with or without LOADER_CHECKSUM_EN.
interface tree_node_loader_if
    import tree_pkg::*;
#(
    parameter int NODE_WIDTH = NODE_WIDTH_DEF,
    parameter int NODE_ADDR  = NODE_ADDR_DEF
);
    logic [7:0]            cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  mem_we;
    logic [NODE_ADDR-1:0]  mem_addr;
    logic [NODE_WIDTH-1:0] mem_din;

    modport master (output cfg_data, cfg_valid, input cfg_ready, mem_we, mem_addr, mem_din);
    modport slave  (input cfg_data, cfg_valid, output cfg_ready, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/node_assembler.sv
// Byte-to-word shift register: bytes arrive LSB first, word_valid pulses
// the cycle after the final byte of a node. Unaffected by LOADER_CHECKSUM_EN.
module node_assembler
    import tree_pkg::*;
#(
    parameter int NODE_WIDTH = NODE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  byte_last,
    output logic                  word_valid,
    output logic [NODE_WIDTH-1:0] word
);
    localparam int NB = NODE_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] byte_cnt;

    assign byte_last = (byte_cnt == CW'(NB - 1));

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && byte_last;
            if (byte_valid) begin
                // new byte enters at the top so the first byte ends in bits [7:0]
                word     <= {byte_in, word[NODE_WIDTH-1:8]};
                byte_cnt <= byte_last ? '0 : byte_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/tree_node_loader.sv
// Byte-serial writer for the root node register and level-2 node table.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module tree_node_loader
    import tree_pkg::*;
#(
    parameter int                    NODE_WIDTH  = NODE_WIDTH_DEF,
    parameter int                    NODE_ADDR   = NODE_ADDR_DEF,
    parameter int                    TABLE_DEPTH = 16,
    parameter logic [NODE_WIDTH-1:0] ROOT_INIT   = ROOT_INIT_DEF
) (
    input  logic                  clk,
    input  logic                  RSTn,
    tree_node_loader_if.slave     bus,
    output logic [NODE_WIDTH-1:0] root_node,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);
    localparam int NB = NODE_WIDTH / 8;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t S_TAIL = S_CSUM;
    logic [7:0] csum;
`else
    localparam loader_state_t S_TAIL = S_DONE;
`endif

    loader_state_t         state, state_nx;
    logic                  ready, accept, err_set, err_q;
    logic                  tgt_l2;
    logic [7:0]            start, cnt, node_idx;
    logic [10:0]           drain_cnt, drain_len;
    logic [8:0]            end_addr;
    logic                  range_ok, last_node;
    logic [NODE_WIDTH-1:0] shadow, root_q, word;
    logic                  byte_last, word_valid;

    assign accept    = bus.cfg_valid && ready;
    assign end_addr  = {1'b0, start} + {1'b0, bus.cfg_data};
    assign range_ok  = tgt_l2 ? (end_addr <= 9'(TABLE_DEPTH)) : (bus.cfg_data == 8'd1);
    assign drain_len = 11'(bus.cfg_data) * 11'(NB) + 11'(CSUM_BYTES);
    assign last_node = (8'(node_idx + 8'd1) == cnt);

    node_assembler #(.NODE_WIDTH(NODE_WIDTH)) u_asm (
        .clk        (clk),
        .RSTn       (RSTn),
        .byte_valid (accept && state == S_DATA),
        .byte_in    (bus.cfg_data),
        .byte_last  (byte_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_nx = state;
        ready    = 1'b1;
        err_set  = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                if (bus.cfg_data > TGT_L2) err_set  = 1'b1;
                else                       state_nx = S_ADDR;
            end
            S_ADDR: if (accept) state_nx = S_CNT;
            S_CNT: if (accept) begin
                if (!range_ok) begin
                    // nothing to drain: reject on the CNT byte itself
                    if (drain_len == 11'd0) begin
                        err_set  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DRAIN;
                    end
                end else if (bus.cfg_data == 8'd0) begin
                    state_nx = S_TAIL;
                end else begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: if (accept && byte_last) state_nx = S_WRITE;
            S_WRITE: begin
                ready    = 1'b0;
                state_nx = last_node ? S_TAIL : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (accept) begin
                if (bus.cfg_data == csum) state_nx = S_DONE;
                else begin
                    err_set  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
`endif
            S_DRAIN: if (accept && drain_cnt == 11'd1) begin
                err_set  = 1'b1;
                state_nx = S_IDLE;
            end
            S_DONE: begin
                ready    = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            err_q     <= 1'b0;
            tgt_l2    <= 1'b0;
            start     <= '0;
            cnt       <= '0;
            node_idx  <= '0;
            drain_cnt <= '0;
            shadow    <= ROOT_INIT;
            root_q    <= ROOT_INIT;
        end else begin
            state <= state_nx;
            err_q <= err_set;
            if (accept && state == S_IDLE) tgt_l2 <= (bus.cfg_data == TGT_L2);
            if (accept && state == S_ADDR) start  <= bus.cfg_data;
            if (accept && state == S_CNT) begin
                cnt       <= bus.cfg_data;
                node_idx  <= '0;
                drain_cnt <= drain_len;
            end
            if (state == S_WRITE) node_idx <= node_idx + 8'd1;
            if (accept && state == S_DRAIN) drain_cnt <= drain_cnt - 11'd1;
            if (word_valid && !tgt_l2) shadow <= word;
            if (state == S_DONE && !tgt_l2) root_q <= shadow;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            csum <= '0;
        end else if (accept) begin
            if (state == S_IDLE) csum <= bus.cfg_data;
            else if (state == S_ADDR || state == S_CNT || state == S_DATA)
                csum <= csum ^ bus.cfg_data;
        end
    end
`endif

    // root_node switches to the new word on the load_done cycle itself
    assign root_node    = (state == S_DONE && !tgt_l2) ? shadow : root_q;
    assign bus.cfg_ready = ready;
    assign bus.mem_we   = word_valid && tgt_l2;
    assign bus.mem_addr = bus.mem_we ? (NODE_ADDR'(start) + NODE_ADDR'(node_idx)) : '0;
    assign bus.mem_din  = bus.mem_we ? word : '0;
    assign busy         = (state != S_IDLE);
    assign load_done    = (state == S_DONE);
    assign load_err     = err_q;
endmodule

// File: tb/tb_tree_node_loader.sv
// Scoreboard bench for tree_node_loader; follows LOADER_CHECKSUM_EN when defined.
module tb_tree_node_loader;
    import tree_pkg::*;

    localparam int NB = 5;

    logic        clk = 1'b0;
    logic        RSTn;
    logic [39:0] root_node;
    logic        busy, load_done, load_err;

    always #5 clk = ~clk;

    tree_node_loader_if #(.NODE_WIDTH(40), .NODE_ADDR(9)) bus ();

    tree_node_loader #(
        .NODE_WIDTH(40), .NODE_ADDR(9), .TABLE_DEPTH(16), .ROOT_INIT(ROOT_INIT_DEF)
    ) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .bus       (bus.slave),
        .root_node (root_node),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    typedef struct { int addr; logic [39:0] data; } wr_t;
    typedef struct { bit is_err; logic [39:0] root; } ev_t;

    wr_t         wq[$];
    ev_t         eq[$];
    logic [39:0] nodes_q[$];
    logic [39:0] root_m;
    bit          stall_en;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT writes or finishes a frame
    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (RSTn === 1'b1) begin
            if (bus.mem_we) begin
                chk("ready_low_in_write", 64'(bus.cfg_ready), 64'd0);
                if (wq.size() == 0) chk("unexpected_write", 64'(bus.mem_addr), 64'hFFFF);
                else begin
                    w = wq.pop_front();
                    chk("write_addr", 64'(bus.mem_addr), 64'(w.addr));
                    chk("write_data", 64'(bus.mem_din), 64'(w.data));
                end
            end
            if (load_done || load_err) begin
                if (eq.size() == 0) chk("unexpected_event", 64'({load_done, load_err}), 64'd0);
                else begin
                    e = eq.pop_front();
                    chk("event_err", 64'(load_err), 64'(e.is_err));
                    chk("event_done", 64'(load_done), 64'(!e.is_err));
                    chk("event_root", 64'(root_node), 64'(e.root));
                    if (load_done) chk("ready_low_in_done", 64'(bus.cfg_ready), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic r;
        if (stall_en && $urandom_range(0, 2) == 0) begin
            bus.cfg_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            r = bus.cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 20);
        bus.cfg_valid = 1'b0;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte %0h never accepted", b);
        end
    endtask

    // reference model: derives the expected writes and frame outcome from the frame fields
    task automatic do_frame(input int tgt, input int addr, input int cnt, input bit corrupt);
        logic [7:0]  fb[$];
        logic [39:0] nd[$];
        logic [39:0] w;
        logic [7:0]  x;
        bit          ok, csum_ok;
        fb.push_back(8'(tgt));
        if (tgt > 1) begin
            eq.push_back('{1'b1, root_m});
        end else begin
            fb.push_back(8'(addr));
            fb.push_back(8'(cnt));
            for (int i = 0; i < cnt; i++) begin
                if (nodes_q.size() > 0) w = nodes_q.pop_front();
                else w = 40'({$urandom(), $urandom()});
                nd.push_back(w);
                for (int k = 0; k < NB; k++) fb.push_back(w[8*k +: 8]);
            end
            x = 8'd0;
            foreach (fb[i]) x ^= fb[i];
`ifdef LOADER_CHECKSUM_EN
            fb.push_back(corrupt ? (x ^ 8'h5A) : x);
            csum_ok = !corrupt;
`else
            csum_ok = 1'b1 | corrupt | (x == 8'd0);
`endif
            ok = (tgt == 1) ? (addr + cnt <= 16) : (cnt == 1);
            if (!ok) eq.push_back('{1'b1, root_m});
            else begin
                if (tgt == 1) foreach (nd[i]) wq.push_back('{addr + i, nd[i]});
                if (csum_ok) begin
                    if (tgt == 0) root_m = nd[0];
                    eq.push_back('{1'b0, root_m});
                end else begin
                    eq.push_back('{1'b1, root_m});
                end
            end
        end
        foreach (fb[i]) send_byte(fb[i]);
        repeat (3) tick();
        chk("frame_events_left", 64'(eq.size()), 64'd0);
        chk("frame_writes_left", 64'(wq.size()), 64'd0);
        chk("idle_after_frame", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [39:0] w0, w1;
        int r, tgt, addr, cnt;
        RSTn          = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'd0;
        root_m        = ROOT_INIT_DEF;
        stall_en      = 1'b0;
        repeat (2) tick();
        chk("rst_ready", 64'(bus.cfg_ready), 64'd1);
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_din", 64'(bus.mem_din), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        chk("rst_root", 64'(root_node), 64'(ROOT_INIT_DEF));
        RSTn = 1'b1;
        tick();

        do_frame(1, 3, 2, 1'b0);
        nodes_q.push_back(40'h01DEADBEEF);
        do_frame(0, 0, 1, 1'b0);
        chk("root_deadbeef", 64'(root_node), 64'h01DEADBEEF);
        do_frame(1, 15, 2, 1'b0);
        do_frame(1, 0, 1, 1'b0);

        // bad target: error pulse on the cycle after the byte, still idle
        eq.push_back('{1'b1, root_m});
        send_byte(8'h07);
        @(negedge clk);
        chk("bad_tgt_err_timing", 64'(load_err), 64'd1);
        chk("bad_tgt_idle", 64'(busy), 64'd0);
        tick();

        do_frame(0, 0, 2, 1'b0);
        do_frame(0, 5, 0, 1'b0);
        do_frame(1, 0, 0, 1'b0);
        do_frame(1, 16, 0, 1'b0);
        do_frame(1, 17, 0, 1'b0);
        do_frame(1, 14, 2, 1'b0);
        do_frame(1, 14, 3, 1'b0);
        do_frame(1, 2, 1, 1'b1);
        do_frame(0, 0, 1, 1'b1);

        stall_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 9);
            tgt  = (r == 0) ? $urandom_range(2, 255) : (r < 4) ? 0 : 1;
            addr = $urandom_range(0, 18);
            cnt  = (tgt == 0) ? (($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : 1)
                              : $urandom_range(0, 4);
            do_frame(tgt, addr, cnt, ($urandom_range(0, 5) == 0));
        end

        // reset mid-DATA after a root load
        stall_en = 1'b0;
        do_frame(0, 0, 1, 1'b0);
        w0 = 40'({$urandom(), $urandom()});
        w1 = 40'({$urandom(), $urandom()});
        wq.push_back('{5, w0});
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h02);
        for (int k = 0; k < NB; k++) send_byte(w0[8*k +: 8]);
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        RSTn = 1'b0;
        #2;
        chk("midrst_root", 64'(root_node), 64'(ROOT_INIT_DEF));
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(bus.cfg_ready), 64'd1);
        chk("midrst_we", 64'(bus.mem_we), 64'd0);
        chk("midrst_din", 64'(bus.mem_din), 64'd0);
        chk("midrst_writes_left", 64'(wq.size()), 64'd0);
        root_m = ROOT_INIT_DEF;
        tick();
        RSTn = 1'b1;
        tick();
        do_frame(1, 0, 1, 1'b0);
        do_frame(0, 0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
